clk_div_prog: RTL and testbench

Multi-channel programmable clock divider. It generates NUM_CH independent divided-clock outputs from sys_clk, each with a runtime-programmable period and high time. Outputs are registered, and each channel also emits a period-start tick pulse. Divisor and high-time updates go through a shadow register and take effect only at a period boundary, so the output never glitches. The block sits beside the system clock input and feeds slow strobes and divided clocks to LED, PWM and sampling logic.

---
 rtl/clk_div_prog.sv | 75 +++++++
 tb/tb_clk_div_prog.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock divider with glitch-free shadowed config
// Ports: sys_clk/sys_rst (async, active high); en per-channel run enable;
//   wr_en/wr_ch/wr_div/wr_high config write port; wr_err pulses after a rejected write;
//   pending marks an unapplied shadow; clk_out divided clock; tick period-start pulse.
module clk_div_prog #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 8,
  parameter int DEF_DIV = 5,
  parameter int DEF_HIGH = 2,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [CNT_W-1:0]  wr_high,
  output logic              wr_err,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CH_W:0] NCH = NUM_CH[CH_W:0];
  logic wr_ok;
  assign wr_ok = wr_en && ({1'b0, wr_ch} < NCH) && (wr_div >= CNT_W'(2));
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) wr_err <= 1'b0;
    else wr_err <= wr_en && !wr_ok;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, da, ha, ds, hs, ha_n;
    logic wrap, load, hit, pnd, co, tk;
    assign hit = wr_ok && (wr_ch == CH_W'(c));
    // A pending shadow is taken whenever IDLE (enabled or not) or at the last count of a period
    always_comb begin
      wrap = cnt == da - CNT_W'(1);
      load = pnd && (state == IDLE || wrap);
      state_n = en[c] ? RUN : IDLE;
      cnt_n = (state == RUN && en[c] && !wrap) ? cnt + CNT_W'(1) : '0;
      ha_n = load ? hs : ha;
    end
    always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
        state <= IDLE;
        cnt <= '0;
        da <= CNT_W'(DEF_DIV);
        ha <= CNT_W'(DEF_HIGH);
        ds <= CNT_W'(DEF_DIV);
        hs <= CNT_W'(DEF_HIGH);
        pnd <= 1'b0;
        co <= 1'b0;
        tk <= 1'b0;
      end else begin
        state <= state_n;
        cnt <= cnt_n;
        if (load) begin
          da <= ds;
          ha <= hs;
        end
        if (hit) begin
          ds <= wr_div;
          hs <= wr_high;
        end
        // A write on the load edge wins, so it stays pending for the next boundary
        pnd <= hit || (pnd && !load);
        co <= state_n == RUN && cnt_n < ha_n;
        tk <= state_n == RUN && cnt_n == '0;
      end
    assign pending[c] = pnd;
    assign clk_out[c] = co;
    assign tick[c] = tk;
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog
module tb_clk_div_prog;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] en = '0;
  logic wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_div = '0, wr_high = '0;
  logic wr_err;
  logic [2:0] pending, clk_out, tick;
  int checks = 0, errors = 0;

  clk_div_prog #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(5), .DEF_HIGH(2)) dut (
    .sys_clk(clk), .sys_rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_div(wr_div), .wr_high(wr_high), .wr_err(wr_err), .pending(pending),
    .clk_out(clk_out), .tick(tick));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] h);
    wr_en = 1'b1;
    wr_ch = ch;
    wr_div = d;
    wr_high = h;
  endtask

  initial begin
    #12;
    chk("rst_clk", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_err", 32'(wr_err), 0);
    cyc();
    rst = 1'b0;
    en = 3'b001;
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("def_clk0", 32'(clk_out[0]), 32'(i % 5 < 2));
      chk("def_tick0", 32'(tick[0]), 32'(i % 5 == 0));
      chk("def_clk1", 32'(clk_out[1]), 0);
      chk("def_pend", 32'(pending), 0);
      cyc();
    end
    // ch0 at cnt=0; next edge reaches cnt=1, write sampled on the cnt=1 edge
    cyc();
    wr(0, 4, 2);
    cyc();
    wr_en = 1'b0;
    for (int i = 2; i < 5; i++) begin
      chk("bnd_pend", 32'(pending[0]), 1);
      chk("bnd_old_clk", 32'(clk_out[0]), 0);
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      chk("bnd_new_clk", 32'(clk_out[0]), 32'(i % 4 < 2));
      chk("bnd_new_tick", 32'(tick[0]), 32'(i % 4 == 0));
      chk("bnd_pend_clr", 32'(pending[0]), 0);
      cyc();
    end
    // ch1 idle: new config loads on the following edge
    wr(1, 7, 0);
    cyc();
    wr_en = 1'b0;
    chk("idle_pend_set", 32'(pending[1]), 1);
    cyc();
    chk("idle_pend_clr", 32'(pending[1]), 0);
    en[1] = 1'b1;
    cyc();
    for (int i = 0; i < 14; i++) begin
      chk("h0_clk", 32'(clk_out[1]), 0);
      chk("h0_tick", 32'(tick[1]), 32'(i % 7 == 0));
      cyc();
    end
    en[1] = 1'b0;
    wr(1, 3, 3);
    cyc();
    wr_en = 1'b0;
    chk("hd_off", 32'(clk_out[1]), 0);
    cyc();
    en[1] = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk("hd_clk", 32'(clk_out[1]), 1);
      chk("hd_tick", 32'(tick[1]), 32'(i % 3 == 0));
      cyc();
    end
    // rejected writes
    chk("err_idle", 32'(wr_err), 0);
    wr(0, 1, 0);
    cyc();
    wr_en = 1'b0;
    chk("err_div", 32'(wr_err), 1);
    chk("err_div_pend", 32'(pending), 0);
    cyc();
    chk("err_div_clr", 32'(wr_err), 0);
    wr(3, 6, 1);
    cyc();
    wr_en = 1'b0;
    chk("err_ch", 32'(wr_err), 1);
    chk("err_ch_pend", 32'(pending), 0);
    cyc();
    chk("err_ch_clr", 32'(wr_err), 0);
    // resync ch0 with disable/enable; D=4,H=2 must be intact
    en[0] = 1'b0;
    cyc();
    chk("dis_clk", 32'(clk_out[0]), 0);
    chk("dis_tick", 32'(tick[0]), 0);
    en[0] = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("keep_clk", 32'(clk_out[0]), 32'(i % 4 < 2));
      chk("keep_tick", 32'(tick[0]), 32'(i % 4 == 0));
      cyc();
    end
    // collision: A pending, B written on the edge that loads A
    wr(0, 5, 1);
    cyc();
    wr_en = 1'b0;
    chk("col_pendA", 32'(pending[0]), 1);
    cyc();
    cyc();
    wr(0, 6, 3);
    cyc();
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("colA_clk", 32'(clk_out[0]), 32'(i < 1));
      chk("colA_tick", 32'(tick[0]), 32'(i == 0));
      chk("colA_pend", 32'(pending[0]), 1);
      cyc();
    end
    for (int i = 0; i < 12; i++) begin
      chk("colB_clk", 32'(clk_out[0]), 32'(i % 6 < 3));
      chk("colB_tick", 32'(tick[0]), 32'(i % 6 == 0));
      chk("colB_pend", 32'(pending[0]), 0);
      cyc();
    end
    // mid-period disable and restart
    cyc();
    chk("mid_hi", 32'(clk_out[0]), 1);
    en[0] = 1'b0;
    cyc();
    chk("mid_dis", 32'(clk_out[0]), 0);
    cyc();
    chk("mid_dis2", 32'(clk_out[0]), 0);
    en[0] = 1'b1;
    cyc();
    chk("re_clk", 32'(clk_out[0]), 1);
    chk("re_tick", 32'(tick[0]), 1);
    cyc();
    chk("re_hi", 32'(clk_out[0]), 1);
    // async reset mid high phase
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clk", 32'(clk_out), 0);
    chk("arst_tick", 32'(tick), 0);
    chk("arst_pend", 32'(pending), 0);
    cyc();
    cyc();
    rst = 1'b0;
    en = 3'b001;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("post_clk", 32'(clk_out[0]), 32'(i < 2));
      chk("post_tick", 32'(tick[0]), 32'(i == 0));
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
